// File: rtl/lzc_pipe_pkg.sv
// Shared types and helpers for the pipelined leading-one / leading-zero counter.
package lzc_pipe_pkg;

    localparam int LZC_W_DEF     = 32;
    localparam int LZC_R_DEF     = 2;
    localparam int LZC_TAG_W_DEF = 4;

    // Largest supported operand is 128 bits, so a position never needs more than 7 bits.
    localparam int POS_MAX = 7;

    // Ceiling log2 for elaboration-time width arithmetic.
    function automatic int clog2(input int x);
        int r;
        r = 0;
        while ((1 << r) < x) r++;
        return r;
    endfunction

    // One tree node: "some bit set" plus the index of the leading one inside its span.
    // Bits of pos above the node's level are always zero.
    typedef struct packed {
        logic               v;
        logic [POS_MAX-1:0] pos;
    } node_t;

endpackage

// File: rtl/lzc_merge.sv
// One combinational merge node of the leading-one tree.
// HW is the width in operand bits of each input half.
import lzc_pipe_pkg::*;

module lzc_merge #(
    parameter int HW = 1
) (
    input  node_t hi,
    input  node_t lo,
    output node_t o
);

    localparam int K = clog2(HW);

    // High half has priority; bit K of the merged position says which half it came from.
    always_comb begin
        o        = lo;
        o.v      = hi.v | lo.v;
        o.pos    = hi.v ? hi.pos : lo.pos;
        o.pos[K] = hi.v;
    end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-one detector / leading-zero counter.
// log2(W) merge levels, register after every R levels, valid/ready on both sides.
// Optional macro LZC_PIPE_NORM_EN adds out_norm = operand << out_lz.
import lzc_pipe_pkg::*;

module lzc_pipe #(
    parameter int W     = LZC_W_DEF,
    parameter int R     = LZC_R_DEF,
    parameter int TAG_W = LZC_TAG_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_a,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(W)-1:0]   out_pos,
    output logic                  out_v,
    output logic [clog2(W):0]     out_lz,
`ifdef LZC_PIPE_NORM_EN
    output logic [W-1:0]          out_norm,
`endif
    output logic [TAG_W-1:0]      out_tag
);

    localparam int L = clog2(W);
    localparam int N = (L + R - 1) / R;

    // Tree level at which stage s ends (its register sits after this level).
    function automatic int stage_end(input int s);
        return ((s + 1) * R < L) ? (s + 1) * R : L;
    endfunction

    node_t lv [0:L-1][0:W-1];   // inputs to each level (post-register at stage boundaries)
    node_t mg [1:L][0:W-1];     // merge outputs per level; unused slots tied to zero
    node_t st [0:N-1][0:W-1];   // stage registers

    logic [TAG_W-1:0] tg     [0:N-1];
    logic [TAG_W-1:0] up_tag [0:N-1];
    logic [N-1:0]     vld, ld, up_v;
`ifdef LZC_PIPE_NORM_EN
    logic [W-1:0]     opr    [0:N-1];
    logic [W-1:0]     up_a   [0:N-1];
`endif

    node_t            fin;
    logic [L:0]       lz_full;

    genvar gk, gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_leaf
            assign lv[0][gi] = {in_a[gi], {POS_MAX{1'b0}}};
        end

        for (gk = 1; gk <= L; gk++) begin : g_lvl
            for (gi = 0; gi < W; gi++) begin : g_node
                if (gi < (W >> gk)) begin : g_m
                    lzc_merge #(.HW(1 << (gk - 1))) u_merge (
                        .hi (lv[gk-1][2*gi+1]),
                        .lo (lv[gk-1][2*gi]),
                        .o  (mg[gk][gi])
                    );
                end else begin : g_z
                    assign mg[gk][gi] = '0;
                end
            end
            if (gk < L) begin : g_fwd
                for (gi = 0; gi < W; gi++) begin : g_f
                    if (gk % R == 0) begin : g_reg
                        assign lv[gk][gi] = st[(gk-1)/R][gi];
                    end else begin : g_cmb
                        assign lv[gk][gi] = mg[gk][gi];
                    end
                end
            end
        end
    endgenerate

    // Load enables ripple back from the consumer so empty stages fill even under stall.
    always_comb begin
        ld        = '0;
        ld[N-1]   = !vld[N-1] || out_ready;
        for (int s = N - 2; s >= 0; s--) ld[s] = !vld[s] || ld[s+1];
    end

    assign in_ready = ld[0];

    // What each stage would capture: the upstream stage's valid, tag and operand.
    always_comb begin
        up_v = '0;
        for (int s = 0; s < N; s++) up_tag[s] = '0;
`ifdef LZC_PIPE_NORM_EN
        for (int s = 0; s < N; s++) up_a[s] = '0;
        up_a[0] = in_a;
`endif
        up_v[0]   = in_valid;
        up_tag[0] = in_tag;
        for (int s = 1; s < N; s++) begin
            up_v[s]   = vld[s-1];
            up_tag[s] = tg[s-1];
`ifdef LZC_PIPE_NORM_EN
            up_a[s]   = opr[s-1];
`endif
        end
    end

    // Stage registers; data only moves with a valid item so outputs hold when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            for (int s = 0; s < N; s++) begin
                tg[s] <= '0;
`ifdef LZC_PIPE_NORM_EN
                opr[s] <= '0;
`endif
                for (int i = 0; i < W; i++) st[s][i] <= '0;
            end
        end else begin
            for (int s = 0; s < N; s++) begin
                if (ld[s]) begin
                    vld[s] <= up_v[s];
                    if (up_v[s]) begin
                        tg[s] <= up_tag[s];
`ifdef LZC_PIPE_NORM_EN
                        opr[s] <= up_a[s];
`endif
                        for (int i = 0; i < W; i++) st[s][i] <= mg[stage_end(s)][i];
                    end
                end
            end
        end
    end

    // Result decode from the last stage; out_lz reads zero while nothing is presented.
    always_comb begin
        fin       = st[N-1][0];
        lz_full   = fin.v ? ((L+1)'(W - 1) - (L+1)'(fin.pos[L-1:0])) : (L+1)'(W);
        out_valid = vld[N-1];
        out_v     = fin.v;
        out_pos   = fin.pos[L-1:0];
        out_tag   = tg[N-1];
        out_lz    = vld[N-1] ? lz_full : '0;
`ifdef LZC_PIPE_NORM_EN
        out_norm  = opr[N-1] << lz_full;
`endif
    end

endmodule

// File: tb/tb_lzc_pipe.sv
// Self-checking bench for lzc_pipe (W=32, R=2, N=3) against a bit-scan reference model.
// Honours LZC_PIPE_NORM_EN when the design is built with it.
module tb_lzc_pipe;

    localparam int W  = 32;
    localparam int R  = 2;
    localparam int TW = 4;
    localparam int NL = 3;

    logic          clock, reset;
    logic          in_valid, in_ready, out_valid, out_ready, out_v;
    logic [31:0]   in_a;
    logic [3:0]    in_tag, out_tag;
    logic [4:0]    out_pos;
    logic [5:0]    out_lz;
`ifdef LZC_PIPE_NORM_EN
    logic [31:0]   out_norm;
`endif

    typedef struct packed {
        logic        v;
        logic [4:0]  pos;
        logic [5:0]  lz;
        logic [3:0]  tag;
        logic [31:0] norm;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    logic [31:0] qa [$];
    logic [3:0]  qt [$];
    int          qc [$];

    lzc_pipe #(.W(W), .R(R), .TAG_W(TW)) dut (
`ifdef LZC_PIPE_NORM_EN
        .out_norm  (out_norm),
`endif
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_v     (out_v),
        .out_lz    (out_lz),
        .out_tag   (out_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: scan for the highest set bit; normalisation is a plain shift.
    function automatic res_t model(input logic [31:0] a, input logic [3:0] t);
        res_t r;
        int   lz;
        lz = 32;
        for (int i = 0; i < 32; i++) if (a[i]) lz = 31 - i;
        r.v    = (a != 0);
        r.pos  = (a != 0) ? 5'(31 - lz) : 5'd0;
        r.lz   = 6'(lz);
        r.tag  = t;
`ifdef LZC_PIPE_NORM_EN
        r.norm = (lz == 32) ? 32'h0 : (a << lz);
`else
        r.norm = 32'h0;
`endif
        return r;
    endfunction

    // One clock: sample handshake pre-edge, record accepted operands, advance.
    task automatic tick(output bit acc, output bit emt, output res_t r, output int cy);
        logic [31:0] nv;
        #1;
`ifdef LZC_PIPE_NORM_EN
        nv = out_norm;
`else
        nv = 32'h0;
`endif
        acc = in_valid && in_ready;
        emt = out_valid && out_ready;
        r   = {out_v, out_pos, out_lz, out_tag, nv};
        cy  = cyc_n;
        if (acc) begin
            qa.push_back(in_a);
            qt.push_back(in_tag);
            qc.push_back(cyc_n);
        end
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    task automatic test_reset();
        in_valid = 0; out_ready = 0; in_a = '0; in_tag = '0;
        reset = 0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_v !== 1'b0)     begin n_bad++; $display("FAIL reset_out_v: got %b want 0", out_v); end
        n_cmp++; if (out_pos !== 5'd0)   begin n_bad++; $display("FAIL reset_out_pos: got %0d want 0", out_pos); end
        n_cmp++; if (out_lz !== 6'd0)    begin n_bad++; $display("FAIL reset_out_lz: got %0d want 0", out_lz); end
        n_cmp++; if (out_tag !== 4'd0)   begin n_bad++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
        reset = 1;
        @(posedge clock);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] ops [5] = '{32'h0001_0000, 32'h0, 32'h8000_0000, 32'h1, 32'h00F0_0000};
        int          lzt [5] = '{15, 32, 0, 31, 8};
        bit acc, emt; res_t r, e; int cy, acy; bit got;
        for (int k = 0; k < 5; k++) begin
            in_a = ops[k]; in_tag = 4'(k + 5); in_valid = 1; out_ready = 1;
            tick(acc, emt, r, cy);
            acy = cy;
            n_cmp++; if (!acc) begin n_bad++; $display("FAIL dir_accept[%0d]: got 0 want 1", k); end
            in_valid = 0;
            got = 0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick(acc, emt, r, cy);
                if (emt) begin
                    got = 1;
                    e = model(qa.pop_front(), qt.pop_front());
                    void'(qc.pop_front());
                    n_cmp++; if (cy - acy != NL) begin n_bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", k, cy - acy, NL); end
                    n_cmp++; if (r !== e) begin n_bad++; $display("FAIL dir_result[%0d]: got %h want %h", k, r, e); end
                    n_cmp++; if (r.lz !== 6'(lzt[k])) begin n_bad++; $display("FAIL dir_lz[%0d]: got %0d want %0d", k, r.lz, lzt[k]); end
`ifdef LZC_PIPE_NORM_EN
                    if (k == 4) begin
                        n_cmp++; if (r.norm !== 32'hF000_0000) begin n_bad++; $display("FAIL dir_norm: got %h want f0000000", r.norm); end
                    end
                    if (k == 1) begin
                        n_cmp++; if (r.norm !== 32'h0) begin n_bad++; $display("FAIL dir_norm_zero: got %h want 0", r.norm); end
                    end
`endif
                end
            end
            if (!got) begin n_cmp++; n_bad++; $display("FAIL dir_timeout[%0d]: got no result want one", k); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [4] = '{32'hF, 32'h100, 32'h7FFF_FFFF, 32'h2};
        int          lzt [4] = '{28, 23, 1, 30};
        bit acc, emt; res_t r, e; int cy, idx, nout, last;
        idx = 0; nout = 0; last = 0;
        out_ready = 1;
        for (int t = 0; t < 20 && nout < 4; t++) begin
            in_valid = (idx < 4);
            in_a     = (idx < 4) ? ops[idx] : 32'h0;
            in_tag   = 4'(idx);
            tick(acc, emt, r, cy);
            if (acc) idx++;
            if (emt) begin
                e = model(qa.pop_front(), qt.pop_front());
                void'(qc.pop_front());
                n_cmp++; if (r !== e) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", nout, r, e); end
                n_cmp++; if (r.lz !== 6'(lzt[nout]) || r.tag !== 4'(nout)) begin n_bad++; $display("FAIL b2b_order[%0d]: got lz %0d tag %0d want lz %0d tag %0d", nout, r.lz, r.tag, lzt[nout], nout); end
                if (nout > 0) begin
                    n_cmp++; if (cy - last != 1) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %0d want 1", nout, cy - last); end
                end
                last = cy;
                nout++;
            end
        end
        in_valid = 0;
        n_cmp++; if (nout != 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", nout); end
    endtask

    task automatic test_stall();
        bit acc, emt; res_t r, e, snap; int cy, nacc, nout; bit have;
        nacc = 0; have = 0; nout = 0;
        out_ready = 0; in_valid = 1;
        for (int t = 0; t < 6; t++) begin
            in_a = $urandom() >> $urandom_range(0, 32);
            in_tag = 4'($urandom_range(0, 15));
            tick(acc, emt, r, cy);
            if (acc) nacc++;
            if (have) begin
                n_cmp++; if (r !== snap) begin n_bad++; $display("FAIL stall_hold[%0d]: got %h want %h", t, r, snap); end
            end
            if (out_valid && !have) begin
                #1;
                snap = {out_v, out_pos, out_lz, out_tag, r.norm};
                have = 1;
            end
        end
        n_cmp++; if (nacc != NL)      begin n_bad++; $display("FAIL stall_accepts: got %0d want %0d", nacc, NL); end
        n_cmp++; if (in_ready !== 0)  begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1) begin n_bad++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
        in_valid = 0; out_ready = 1;
        for (int t = 0; t < 20 && qa.size() > 0; t++) begin
            tick(acc, emt, r, cy);
            if (emt) begin
                e = model(qa.pop_front(), qt.pop_front());
                void'(qc.pop_front());
                nout++;
                n_cmp++; if (r !== e) begin n_bad++; $display("FAIL stall_drain[%0d]: got %h want %h", nout, r, e); end
            end
        end
        n_cmp++; if (nout != NL || qa.size() != 0) begin n_bad++; $display("FAIL stall_drain_count: got %0d left %0d want %0d left 0", nout, qa.size(), NL); end
        #1;
        n_cmp++; if (out_valid !== 0) begin n_bad++; $display("FAIL stall_dup: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        bit acc, emt; res_t r; int cy, stale;
        stale = 0;
        out_ready = 0; in_valid = 1;
        for (int t = 0; t < 2; t++) begin
            in_a = 32'h1 << t; in_tag = 4'(t);
            tick(acc, emt, r, cy);
        end
        in_valid = 0;
        tick(acc, emt, r, cy);
        n_cmp++; if (out_valid !== 1) begin n_bad++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
        #2 reset = 0;
        #1;
        n_cmp++; if (out_valid !== 0 || out_v !== 0 || out_lz !== 0) begin n_bad++; $display("FAIL rmid_clear: got valid %b v %b lz %0d want 0 0 0", out_valid, out_v, out_lz); end
        qa.delete(); qt.delete(); qc.delete();
        @(posedge clock);
        #1 reset = 1;
        out_ready = 1;
        #1;
        n_cmp++; if (in_ready !== 1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        for (int t = 0; t < 8; t++) begin
            tick(acc, emt, r, cy);
            if (emt) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rmid_stale: got %0d results want 0", stale); end
    endtask

    task automatic test_random();
        bit acc, emt; res_t r, e; int cy, nout, lat_bad;
        nout = 0; lat_bad = 0;
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_a      = $urandom() >> $urandom_range(0, 32);
            in_tag    = 4'($urandom_range(0, 15));
            tick(acc, emt, r, cy);
            if (emt) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++; $display("FAIL rand_extra: got a result with nothing outstanding");
                end else begin
                    e = model(qa.pop_front(), qt.pop_front());
                    if (cy - qc.pop_front() < NL) lat_bad++;
                    if (r !== e) begin n_bad++; $display("FAIL rand_result[%0d]: got %h want %h", nout, r, e); end
                end
                nout++;
            end
        end
        in_valid = 0; out_ready = 1;
        for (int t = 0; t < 20 && qa.size() > 0; t++) begin
            tick(acc, emt, r, cy);
            if (emt) begin
                e = model(qa.pop_front(), qt.pop_front());
                void'(qc.pop_front());
                n_cmp++; if (r !== e) begin n_bad++; $display("FAIL rand_drain: got %h want %h", r, e); end
            end
        end
        n_cmp++; if (qa.size() != 0) begin n_bad++; $display("FAIL rand_lost: got %0d outstanding want 0", qa.size()); end
        n_cmp++; if (lat_bad != 0)   begin n_bad++; $display("FAIL rand_latency: got %0d early results want 0", lat_bad); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
